// File: rtl/uart_byte_avg_filter.sv
// uart_byte_avg_filter: 8-sample sliding-window average of UART bytes
// with truncating divide, drop of out-of-range samples and hysteresis alarm.
module uart_byte_avg_filter #(
  parameter int WIN_LOG2  = 3,
  parameter int MAX_VALID = 200,
  parameter int THRESH_HI = 150,
  parameter int THRESH_LO = 100
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              flush,
  output logic [7:0]        avg_out,
  output logic              avg_valid,
  output logic              alarm,
  output logic              dropped,
  output logic [WIN_LOG2:0] fill_level
);

  localparam int DEPTH = 1 << WIN_LOG2;
  localparam int SW    = 8 + WIN_LOG2;
  localparam int CW    = WIN_LOG2 + 1;

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [7:0]    MAXV = 8'(MAX_VALID);
  localparam logic [7:0]    HI   = 8'(THRESH_HI);
  localparam logic [7:0]    LO   = 8'(THRESH_LO);

  logic [7:0]          ring [DEPTH];
  logic [WIN_LOG2-1:0] wr_ptr;
  logic [SW-1:0]       sum;
  logic [CW-1:0]       count;
  logic                upd_pend;

  logic          accept;
  logic          reject;
  logic          full;
  logic [7:0]    oldest;
  logic [7:0]    avg_next;
  logic [SW-1:0] sum_next;

  assign accept     = in_valid && (in_data <= MAXV) && !flush;
  assign reject     = in_valid && (in_data > MAXV) && !flush;
  assign full       = (count == FULL);
  assign oldest     = full ? ring[wr_ptr] : 8'd0;
  assign sum_next   = sum + SW'(in_data) - SW'(oldest);
  assign avg_next   = sum[SW-1:WIN_LOG2];
  assign fill_level = count;

  // Only slots already written are ever read back, so no reset needed.
  always_ff @(posedge CLOCK_50) begin
    if (accept) ring[wr_ptr] <= in_data;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      sum       <= '0;
      count     <= '0;
      upd_pend  <= 1'b0;
      avg_out   <= 8'd0;
      avg_valid <= 1'b0;
      alarm     <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      dropped  <= reject;
      upd_pend <= accept;

      if (flush) begin
        wr_ptr <= '0;
        sum    <= '0;
        count  <= '0;
      end else if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        sum    <= sum_next;
        if (!full) count <= count + 1'b1;
      end

      // A flush also kills the update of the sample accepted just before it.
      if (upd_pend && full && !flush) begin
        avg_out   <= avg_next;
        avg_valid <= 1'b1;
        unique case (1'b1)
          avg_next >= HI: alarm <= 1'b1;
          avg_next <= LO: alarm <= 1'b0;
          default:        ;
        endcase
      end else begin
        avg_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_byte_avg_filter.sv
// tb_uart_byte_avg_filter: directed bench for the sliding-window
// average filter with hand-computed expected averages and alarm states.
module tb_uart_byte_avg_filter;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       flush;
  logic [7:0] avg_out;
  logic       avg_valid;
  logic       alarm;
  logic       dropped;
  logic [3:0] fill_level;

  int tests;
  int fails;
  int vcnt;
  int dcnt;
  logic [7:0] avq [$];
  logic       alq [$];

  uart_byte_avg_filter dut (
    .CLOCK_50  (clk),
    .reset_n   (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .flush     (flush),
    .avg_out   (avg_out),
    .avg_valid (avg_valid),
    .alarm     (alarm),
    .dropped   (dropped),
    .fill_level(fill_level)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (avg_valid === 1'b1) begin
      vcnt++;
      avq.push_back(avg_out);
      alq.push_back(alarm);
    end
    if (dropped === 1'b1) dcnt++;
  end

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] v);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic check_queue(input string tag, input logic [7:0] ea [8],
                             input logic ela [8], input int n);
    check({tag, "_count"}, 16'(avq.size()), 16'(n));
    for (int i = 0; i < n; i++) begin
      if (avq.size() > 0) begin
        check($sformatf("%s_avg%0d", tag, i), 16'(avq.pop_front()),
              16'(ea[i]));
        check($sformatf("%s_alarm%0d", tag, i), 16'(alq.pop_front()),
              16'(ela[i]));
      end
    end
  endtask

  int v0;
  int d0;
  logic [7:0] ea [8];
  logic       ela [8];

  initial begin
    tests = 0; fails = 0; vcnt = 0; dcnt = 0;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; in_data = 8'd0;
    idle(3); #1;
    check("rst_avg", 16'(avg_out), 16'd0);
    check("rst_valid", 16'(avg_valid), 16'd0);
    check("rst_alarm", 16'(alarm), 16'd0);
    check("rst_dropped", 16'(dropped), 16'd0);
    check("rst_fill", 16'(fill_level), 16'd0);
    rst_n = 1'b1;

    // Warm-up at UART byte spacing
    for (int i = 0; i < 7; i++) begin
      send(8'd100);
      idle(5200);
    end
    check("warm_no_valid", 16'(vcnt), 16'd0);
    check("warm_fill7", 16'(fill_level), 16'd7);
    send(8'd100);
    @(negedge clk);
    check("warm_lat1_valid", 16'(avg_valid), 16'd0);
    check("warm_fill8", 16'(fill_level), 16'd8);
    @(negedge clk);
    check("warm_lat2_valid", 16'(avg_valid), 16'd1);
    check("warm_avg", 16'(avg_out), 16'd100);
    check("warm_alarm", 16'(alarm), 16'd0);
    idle(5);
    check("warm_one_pulse", 16'(vcnt), 16'd1);
    avq.delete(); alq.delete();

    // Sliding: 900/8=112, 1000/8=125, 1100/8=137, 1200/8=150
    for (int i = 0; i < 4; i++) begin
      send(8'd200);
      idle(10);
    end
    ea  = '{8'd112, 8'd125, 8'd137, 8'd150, 8'd0, 8'd0, 8'd0, 8'd0};
    ela = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    check_queue("slide", ea, ela, 4);

    // Back-to-back 100s: first four overwrite the older 100s, then the 200s
    v0 = vcnt;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'd100;
    idle(8); #1;
    in_valid = 1'b0;
    idle(5);
    check("b2b_pulses", 16'(vcnt - v0), 16'd8);
    ea  = '{8'd150, 8'd150, 8'd150, 8'd150,
            8'd137, 8'd125, 8'd112, 8'd100};
    ela = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    check_queue("hyst", ea, ela, 8);

    // Out-of-range samples
    v0 = vcnt; d0 = dcnt;
    send(8'd201);
    @(negedge clk);
    check("drop201_strobe", 16'(dropped), 16'd1);
    send(8'd255);
    @(negedge clk);
    check("drop255_strobe", 16'(dropped), 16'd1);
    idle(5);
    check("drop_count", 16'(dcnt - d0), 16'd2);
    check("drop_no_valid", 16'(vcnt - v0), 16'd0);
    check("drop_fill", 16'(fill_level), 16'd8);
    check("drop_avg", 16'(avg_out), 16'd100);

    // Flush wins over a simultaneous sample
    v0 = vcnt; d0 = dcnt;
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_data = 8'd50;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_fill", 16'(fill_level), 16'd0);
    check("flush_no_drop", 16'(dropped), 16'd0);
    idle(5);
    check("flush_no_valid", 16'(vcnt - v0), 16'd0);
    check("flush_dcnt", 16'(dcnt - d0), 16'd0);
    check("flush_avg_hold", 16'(avg_out), 16'd100);
    check("flush_alarm_hold", 16'(alarm), 16'd0);

    // Refill, then flush right after an accepted sample
    v0 = vcnt;
    for (int i = 0; i < 8; i++) begin
      send(8'd60);
      idle(3);
    end
    check("refill_pulse", 16'(vcnt - v0), 16'd1);
    check("refill_avg", 16'(avg_out), 16'd60);
    v0 = vcnt;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'd180;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    idle(5);
    check("flush_pend_no_valid", 16'(vcnt - v0), 16'd0);
    check("flush_pend_fill", 16'(fill_level), 16'd0);
    check("flush_pend_avg", 16'(avg_out), 16'd60);

    // Async reset one cycle after the 8th sample
    for (int i = 0; i < 7; i++) begin
      send(8'd200);
      idle(2);
    end
    v0 = vcnt;
    send(8'd200);
    rst_n = 1'b0;
    #1;
    check("arst_avg", 16'(avg_out), 16'd0);
    check("arst_valid", 16'(avg_valid), 16'd0);
    check("arst_alarm", 16'(alarm), 16'd0);
    check("arst_fill", 16'(fill_level), 16'd0);
    idle(2); #1;
    rst_n = 1'b1;
    idle(10);
    check("arst_no_valid", 16'(vcnt - v0), 16'd0);
    check("arst_avg_after", 16'(avg_out), 16'd0);
    check("arst_fill_after", 16'(fill_level), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
